// File: rtl/aurora_ctrl_pkg.sv
// Shared types and constants for the Aurora link bring-up controller and its TX scheduler.
package aurora_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RESET   = 3'd1,
      WAIT_GB = 3'd2,
      TRAIN   = 3'd3,
      LINKED  = 3'd4
   } link_state_t;

   localparam logic [1:0]  SYNC_DATA = 2'b01;
   localparam logic [1:0]  SYNC_CTRL = 2'b10;
   localparam logic [63:0] IDLE_WORD = 64'h7810_0000_0000_0000;
   localparam logic [63:0] CB_WORD   = 64'h7840_0000_0000_0000;

endpackage

// File: rtl/aurora_link_ctrl_if.sv
// User-side and lane-side signal bundle of the Aurora link controller.
interface aurora_link_ctrl_if #(
   parameter int NUM_LANES = 8
) ();

   // A user word transfers on a clock edge where user_valid and user_ready are both high;
   // user_ready may depend combinationally on the lane handshakes but never on user_valid.
   logic [NUM_LANES*64-1:0] user_data;
   logic                    user_valid;
   logic                    user_ready;
   logic [NUM_LANES-1:0]    tx_gearbox_rdy;
   logic [NUM_LANES-1:0]    tx_data_next;
   logic [NUM_LANES*64-1:0] tx_data;
   logic [NUM_LANES*2-1:0]  tx_sync;
   logic [NUM_LANES-1:0]    rx_gearbox_rdy;
   logic [NUM_LANES-1:0]    rx_blocksync;
   logic                    lane_rst;

   modport master (
      input  user_data, user_valid, tx_gearbox_rdy, tx_data_next, rx_gearbox_rdy, rx_blocksync,
      output user_ready, tx_data, tx_sync, lane_rst
   );

   modport slave (
      output user_data, user_valid, tx_gearbox_rdy, tx_data_next, rx_gearbox_rdy, rx_blocksync,
      input  user_ready, tx_data, tx_sync, lane_rst
   );

endinterface

// File: rtl/aurora_tx_scheduler.sv
// Beat detection, channel-bonding cadence and per-lane TX word/sync registers.
module aurora_tx_scheduler
   import aurora_ctrl_pkg::*;
#(
   parameter int NUM_LANES = 8,
   parameter int CB_PERIOD = 256
) (
   input  logic                    clk40,
   input  logic                    rst,
   input  logic                    linked,
   input  logic                    train,
   input  logic                    force_idle,
   input  logic [NUM_LANES*64-1:0] user_data,
   input  logic                    user_valid,
   output logic                    user_ready,
   input  logic [NUM_LANES-1:0]    tx_gearbox_rdy,
   input  logic [NUM_LANES-1:0]    tx_data_next,
   output logic [NUM_LANES*64-1:0] tx_data,
   output logic [NUM_LANES*2-1:0]  tx_sync
);

   localparam int CW = $clog2(CB_PERIOD);

   logic                    beat;
   logic                    cb_slot;
   logic [CW-1:0]           cb_cnt;
   logic [NUM_LANES*64-1:0] data_next;
   logic [NUM_LANES*2-1:0]  sync_next;

   assign beat       = &tx_gearbox_rdy & &tx_data_next;
   assign cb_slot    = (cb_cnt == '0);
   assign user_ready = linked & beat & ~cb_slot;

   always_comb begin
      data_next = tx_data;
      sync_next = tx_sync;
      if (force_idle || (train && beat)) begin
         for (int j = 0; j < NUM_LANES; j++) begin
            data_next[64*j +: 64] = IDLE_WORD;
            sync_next[2*j +: 2]   = SYNC_CTRL;
         end
      end else if (linked && beat) begin
         for (int j = 0; j < NUM_LANES; j++) begin
            if (cb_slot) begin
               data_next[64*j +: 64] = CB_WORD;
               sync_next[2*j +: 2]   = SYNC_CTRL;
            end else if (user_valid) begin
               data_next[64*j +: 64] = user_data[64*j +: 64];
               sync_next[2*j +: 2]   = SYNC_DATA;
            end else begin
               data_next[64*j +: 64] = IDLE_WORD;
               sync_next[2*j +: 2]   = SYNC_CTRL;
            end
         end
      end
   end

   always_ff @(posedge clk40) begin
      if (rst) begin
         tx_data <= '0;
         tx_sync <= '0;
         cb_cnt  <= '0;
      end else begin
         tx_data <= data_next;
         tx_sync <= sync_next;
         if (!linked) begin
            cb_cnt <= '0;
         end else if (beat) begin
            cb_cnt <= (cb_cnt == CW'(CB_PERIOD - 1)) ? '0 : cb_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/aurora_link_ctrl.sv
// Aurora link bring-up FSM (reset, gearbox wait, training, linked) with retrain accounting.
module aurora_link_ctrl
   import aurora_ctrl_pkg::*;
#(
   parameter int NUM_LANES     = 8,
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_WAIT     = 4096,
   parameter int STABLE_CYCLES = 64,
   parameter int CB_PERIOD     = 256
) (
   input  logic               clk40,
   input  logic               rst,
   input  logic               en,
   aurora_link_ctrl_if.master bus,
   output logic               link_up,
   output logic [2:0]         state,
   output logic [7:0]         retrain_cnt
);

   localparam int TW = $clog2((LOCK_WAIT > RST_CYCLES) ? LOCK_WAIT : RST_CYCLES);
   localparam int SW = $clog2(STABLE_CYCLES + 1);

   link_state_t   cur_state;
   link_state_t   state_next;
   logic [TW-1:0] timer;
   logic [SW-1:0] stable_cnt;
   logic          gb_ok;
   logic          in_sync;
   logic          timed_out;
   logic          stable_done;

   assign gb_ok       = &bus.tx_gearbox_rdy & &bus.rx_gearbox_rdy;
   assign in_sync     = &bus.rx_blocksync;
   assign timed_out   = (timer == TW'(LOCK_WAIT - 1));
   assign stable_done = in_sync && (stable_cnt == SW'(STABLE_CYCLES - 1));
   assign state       = cur_state;

   always_comb begin
      state_next = cur_state;
      if (!en) begin
         state_next = IDLE;
      end else begin
         case (cur_state)
            IDLE:    state_next = RESET;
            RESET:   if (timer == TW'(RST_CYCLES - 1)) state_next = WAIT_GB;
            WAIT_GB: if (gb_ok) state_next = TRAIN;
                     else if (timed_out) state_next = RESET;
            // Stable completion wins over a coincident timeout.
            TRAIN:   if (stable_done) state_next = LINKED;
                     else if (timed_out) state_next = RESET;
            LINKED:  if (!in_sync || !(&bus.rx_gearbox_rdy)) state_next = RESET;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk40) begin
      if (rst) begin
         cur_state    <= IDLE;
         timer        <= '0;
         stable_cnt   <= '0;
         retrain_cnt  <= '0;
         link_up      <= 1'b0;
         bus.lane_rst <= 1'b1;
      end else begin
         cur_state    <= state_next;
         timer        <= (state_next != cur_state) ? '0 : timer + 1'b1;
         stable_cnt   <= (cur_state == TRAIN && state_next == TRAIN && in_sync) ? stable_cnt + 1'b1 : '0;
         if (state_next == RESET && cur_state inside {WAIT_GB, TRAIN, LINKED} && retrain_cnt != 8'hFF)
            retrain_cnt <= retrain_cnt + 1'b1;
         link_up      <= (state_next == LINKED);
         bus.lane_rst <= (state_next == IDLE) || (state_next == RESET);
      end
   end

   // The word presented during a sync-loss cycle must not be accepted, so scheduling
   // only runs while the FSM is staying in LINKED.
   aurora_tx_scheduler #(
      .NUM_LANES (NUM_LANES),
      .CB_PERIOD (CB_PERIOD)
   ) u_sched (
      .clk40          (clk40),
      .rst            (rst),
      .linked         ((cur_state == LINKED) && (state_next == LINKED)),
      .train          (cur_state == TRAIN),
      .force_idle     ((state_next == RESET) && (cur_state != RESET)),
      .user_data      (bus.user_data),
      .user_valid     (bus.user_valid),
      .user_ready     (bus.user_ready),
      .tx_gearbox_rdy (bus.tx_gearbox_rdy),
      .tx_data_next   (bus.tx_data_next),
      .tx_data        (bus.tx_data),
      .tx_sync        (bus.tx_sync)
   );

endmodule

// File: tb/tb_aurora_link_ctrl.sv
// Directed bench for aurora_link_ctrl: bring-up, striped data with CB markers, stalls, retrain and override.
module tb_aurora_link_ctrl;
   import aurora_ctrl_pkg::*;

   localparam int NUM_LANES = 8;
   localparam int CB_PERIOD = 256;
   localparam int LOCK_WAIT = 4096;

   logic       clk40 = 1'b0;
   logic       rst   = 1'b1;
   logic       en    = 1'b0;
   logic       link_up;
   logic [2:0] state;
   logic [7:0] retrain_cnt;

   aurora_link_ctrl_if #(.NUM_LANES(NUM_LANES)) bus ();

   aurora_link_ctrl #(
      .NUM_LANES     (NUM_LANES),
      .RST_CYCLES    (16),
      .LOCK_WAIT     (LOCK_WAIT),
      .STABLE_CYCLES (64),
      .CB_PERIOD     (CB_PERIOD)
   ) dut (
      .clk40       (clk40),
      .rst         (rst),
      .en          (en),
      .bus         (bus),
      .link_up     (link_up),
      .state       (state),
      .retrain_cnt (retrain_cnt)
   );

   // Clock / watchdog
   always #5 clk40 = ~clk40;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Scoreboard: {sync, word} per lane for every scheduled beat
   logic [65:0] exp_q[$];
   logic [65:0] held[NUM_LANES];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cb_cnt_m = 0;
   int          seq      = 0;
   bit          vary     = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] gen_word(input int s, input int j);
      return {48'hC0CA_C01A_CAFE, s[7:0], j[7:0]};
   endfunction

   // Driver tasks
   task automatic drive_user();
      for (int j = 0; j < NUM_LANES; j++) bus.user_data[64*j +: 64] = gen_word(seq, j);
   endtask

   task automatic check_all_idle(input string tag);
      for (int j = 0; j < NUM_LANES; j++) begin
         check($sformatf("%s_word%0d", tag, j), bus.tx_data[64*j +: 64], IDLE_WORD);
         check($sformatf("%s_sync%0d", tag, j), 64'(bus.tx_sync[2*j +: 2]), 64'(SYNC_CTRL));
      end
   endtask

   task automatic wait_state(input link_state_t s, input int budget, input string tag, output bit ok);
      int n = 0;
      while (state != s && n < budget) begin
         @(negedge clk40);
         n++;
      end
      ok = (state == s);
      check(tag, 64'(state), 64'(s));
   endtask

   // One LINKED cycle, entered at a negedge with inputs already driven; returns at the next negedge.
   task automatic run_cycle();
      logic beat_m;
      logic accepted;
      #1;
      beat_m   = &bus.tx_gearbox_rdy & &bus.tx_data_next;
      accepted = 1'b0;
      if (!beat_m) begin
         check("stall_ready", 64'(bus.user_ready), 64'd0);
      end else if (cb_cnt_m == 0) begin
         check("cb_ready", 64'(bus.user_ready), 64'd0);
         for (int j = 0; j < NUM_LANES; j++) exp_q.push_back({SYNC_CTRL, CB_WORD});
      end else begin
         check("data_ready", 64'(bus.user_ready), 64'd1);
         accepted = bus.user_valid;
         for (int j = 0; j < NUM_LANES; j++)
            exp_q.push_back(bus.user_valid ? {SYNC_DATA, gen_word(seq, j)} : {SYNC_CTRL, IDLE_WORD});
      end
      if (beat_m) cb_cnt_m = (cb_cnt_m + 1) % CB_PERIOD;
      @(negedge clk40);
      if (exp_q.size() >= NUM_LANES)
         for (int j = 0; j < NUM_LANES; j++) held[j] = exp_q.pop_front();
      for (int j = 0; j < NUM_LANES; j++) begin
         check($sformatf("tx_word%0d", j), bus.tx_data[64*j +: 64], held[j][63:0]);
         check($sformatf("tx_sync%0d", j), 64'(bus.tx_sync[2*j +: 2]), 64'(held[j][65:64]));
      end
      if (accepted && vary) begin
         seq++;
         drive_user();
      end
   endtask

   // Stimulus
   initial begin
      int cyc;
      int rst_cyc;
      bit ok;

      bus.user_valid     = 1'b0;
      bus.user_data      = '0;
      bus.tx_gearbox_rdy = '1;
      bus.tx_data_next   = '1;
      bus.rx_gearbox_rdy = '1;
      bus.rx_blocksync   = '1;
      rst = 1'b1;
      en  = 1'b1;
      repeat (3) @(posedge clk40);
      @(negedge clk40);

      // Reset state
      check("rst_state", 64'(state), 64'(IDLE));
      check("rst_lane_rst", 64'(bus.lane_rst), 64'd1);
      check("rst_link_up", 64'(link_up), 64'd0);
      check("rst_retrain", 64'(retrain_cnt), 64'd0);
      check("rst_user_ready", 64'(bus.user_ready), 64'd0);
      for (int j = 0; j < NUM_LANES; j++) begin
         check($sformatf("rst_word%0d", j), bus.tx_data[64*j +: 64], 64'd0);
         check($sformatf("rst_sync%0d", j), 64'(bus.tx_sync[2*j +: 2]), 64'd0);
      end

      // Bring-up with everything ready and locked
      rst     = 1'b0;
      cyc     = 0;
      rst_cyc = 0;
      while (!link_up && cyc < 300) begin
         @(negedge clk40);
         cyc++;
         if (state == RESET && bus.lane_rst) rst_cyc++;
      end
      check("lane_rst_cycles", 64'(rst_cyc), 64'd16);
      check("link_latency_ok", 64'(cyc <= 2 + 16 + 64 + 8), 64'd1);
      check("link_up", 64'(link_up), 64'd1);
      check("state_linked", 64'(state), 64'(LINKED));
      check("lane_rst_released", 64'(bus.lane_rst), 64'd0);
      check("bringup_retrain", 64'(retrain_cnt), 64'd0);

      // Constant striped user data, CB marker every CB_PERIOD beats
      vary = 1'b0;
      seq  = 0;
      drive_user();
      bus.user_valid = 1'b1;
      cb_cnt_m = 0;
      exp_q.delete();
      for (int j = 0; j < NUM_LANES; j++) held[j] = {SYNC_CTRL, IDLE_WORD};
      repeat (600) run_cycle();

      // Changing data with a lane-5 stall and an idle gap
      vary = 1'b1;
      seq  = 1;
      drive_user();
      repeat (20) run_cycle();
      bus.tx_data_next[5] = 1'b0;
      repeat (10) run_cycle();
      bus.tx_data_next[5] = 1'b1;
      repeat (20) run_cycle();
      bus.user_valid = 1'b0;
      repeat (5) run_cycle();
      bus.user_valid = 1'b1;
      repeat (5) run_cycle();

      // Single-cycle loss of block sync in LINKED
      bus.rx_blocksync[0] = 1'b0;
      #1;
      check("drop_ready", 64'(bus.user_ready), 64'd0);
      @(negedge clk40);
      bus.rx_blocksync = '1;
      check("drop_state", 64'(state), 64'(RESET));
      check("drop_link_up", 64'(link_up), 64'd0);
      check("drop_lane_rst", 64'(bus.lane_rst), 64'd1);
      check("drop_retrain", 64'(retrain_cnt), 64'd1);
      check_all_idle("reset_force");

      // TRAIN timeout with lane 3 never locking
      bus.rx_blocksync[3] = 1'b0;
      wait_state(TRAIN, 100, "reach_train", ok);
      cyc = 0;
      while (state == TRAIN && cyc < 5000) begin
         if (cyc == 20) check_all_idle("train_idle");
         @(negedge clk40);
         cyc++;
      end
      check("train_timeout_cycles", 64'(cyc), 64'(LOCK_WAIT));
      check("timeout_state", 64'(state), 64'(RESET));
      check("timeout_retrain", 64'(retrain_cnt), 64'd2);

      // en deasserted during TRAIN
      wait_state(TRAIN, 100, "reach_train2", ok);
      repeat (3) @(negedge clk40);
      en = 1'b0;
      @(negedge clk40);
      check("en_off_state", 64'(state), 64'(IDLE));
      check("en_off_retrain", 64'(retrain_cnt), 64'd2);
      check("en_off_lane_rst", 64'(bus.lane_rst), 64'd1);
      check("en_off_link_up", 64'(link_up), 64'd0);
      @(negedge clk40);
      check("en_off_hold", 64'(state), 64'(IDLE));

      // Repeated drops saturate the retrain counter
      en = 1'b1;
      bus.rx_blocksync = '1;
      for (int i = 0; i < 300; i++) begin
         wait_state(LINKED, 300, "relink", ok);
         if (!ok) break;
         bus.rx_blocksync[0] = 1'b0;
         @(negedge clk40);
         bus.rx_blocksync[0] = 1'b1;
         if (i == 0)   check("retrain_inc", 64'(retrain_cnt), 64'd3);
         if (i == 252) check("retrain_reach", 64'(retrain_cnt), 64'd255);
      end
      check("retrain_sat", 64'(retrain_cnt), 64'd255);
      check("sat_state", 64'(state), 64'(RESET));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
